// File: rtl/mito_pkg.sv
// Shared definitions for the MITO layer sequencer.
//   mode_e      : layer operating mode carried in instruction bits [1:0]
//   seq_state_e : sequencer FSM states
//   instr_t     : packed view of the 32-bit layer instruction
//   instr_is_illegal : decode check applied when an instruction is offered
package mito_pkg;

   typedef enum logic [1:0] {
      MODE_NOP    = 2'b00,
      MODE_CONVOL = 2'b01,
      MODE_FULLY  = 2'b10,
      MODE_POOL   = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

   // Instruction field layout
   localparam int MODE_LSB   = 0;
   localparam int MODE_W     = 2;
   localparam int NOUT_LSB   = 2;
   localparam int NOUT_W     = 16;
   localparam int LWORDS_LSB = 18;
   localparam int LWORDS_W   = 8;
   localparam int RSVD_LSB   = 26;
   localparam int RSVD_W     = 6;

   typedef struct packed {
      logic [RSVD_W-1:0]   reserved;
      logic [LWORDS_W-1:0] load_words;
      logic [NOUT_W-1:0]   num_outputs;
      mode_e               mode;
   } instr_t;

   // POOL ignores load_words (window size is fixed), so a zero there is fine.
   function automatic logic instr_is_illegal(input instr_t ins);
      return (ins.mode == MODE_NOP) ||
             (ins.num_outputs == '0) ||
             ((ins.load_words == '0) && (ins.mode != MODE_POOL));
   endfunction

endpackage

// File: rtl/mito_wait_timer.sv
// Cycle timer used while the sequencer waits for a completion pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : force count to zero (takes priority over en_i)
//   en_i      : count up by one; saturates at TIMEOUT-1
//   expire_o  : count has reached TIMEOUT-1
module mito_wait_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   assign expire_o = (cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expire_o)
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mito_layer_sequencer.sv
// Instruction-driven sequencer for one MITO layer. Accepts a decoded layer
// instruction in IDLE, then for each output element runs LOAD (word_total
// input words), WAIT (activation or pooling completion), WRITE (one OFM
// strobe), and finally pulses layer_done.
//   instr_valid/instr_ready : instruction handshake; an instruction is taken
//                             in the cycle both are high (ready only in IDLE)
//   instruction             : [1:0] mode, [17:2] num_outputs, [25:18] load_words
//   act_done, pool_done     : completion pulses, only looked at in WAIT
//   layer_signal            : 0 main/activation path, 1 pooling path
//   fully_convol_signal, pooling_signal, data_req : LOAD-phase enables
//   write_signal            : OFM write strobe
//   busy, layer_done, err_illegal, err_timeout : status
// All outputs are decoded from registers only.
module mito_layer_sequencer
   import mito_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int CNT_WIDTH   = 16,
   parameter int LOAD_WIDTH  = 8,
   parameter int POOL_SIZE   = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   act_done,
   input  logic                   pool_done,
   output logic                   layer_signal,
   output logic                   fully_convol_signal,
   output logic                   pooling_signal,
   output logic                   data_req,
   output logic                   write_signal,
   output logic                   busy,
   output logic                   layer_done,
   output logic                   err_illegal,
   output logic                   err_timeout
);

   instr_t ins;
   assign ins = instr_t'(instruction[$bits(instr_t)-1:0]);

   logic unused_rsvd;
   assign unused_rsvd = ^ins.reserved;

   seq_state_e            state_q, state_d;
   mode_e                 mode_q, mode_d;
   logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
   logic [LOAD_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [LOAD_WIDTH-1:0] word_total_q, word_total_d;
   logic                  layer_q, layer_d;
   logic                  err_ill_q, err_ill_d;
   logic                  err_to_q, err_to_d;

   logic timer_clr, timer_en, timer_expire;
   logic done_hit;

   mito_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (timer_clr),
      .en_i     (timer_en),
      .expire_o (timer_expire)
   );

   // Only the pulse belonging to the current mode's path counts.
   assign done_hit = (mode_q == MODE_POOL) ? pool_done : act_done;

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      out_cnt_d    = out_cnt_q;
      word_cnt_d   = word_cnt_q;
      word_total_d = word_total_q;
      layer_d      = layer_q;
      err_ill_d    = 1'b0;
      err_to_d     = 1'b0;
      timer_clr    = 1'b0;
      timer_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               if (instr_is_illegal(ins)) begin
                  err_ill_d = 1'b1;
               end else begin
                  mode_d       = ins.mode;
                  out_cnt_d    = ins.num_outputs;
                  word_total_d = (ins.mode == MODE_POOL) ? LOAD_WIDTH'(POOL_SIZE)
                                                         : ins.load_words;
                  word_cnt_d   = '0;
                  layer_d      = (ins.mode == MODE_POOL);
                  state_d      = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (word_cnt_q == word_total_q - LOAD_WIDTH'(1)) begin
               timer_clr = 1'b1;
               state_d   = ST_WAIT;
            end else begin
               word_cnt_d = word_cnt_q + LOAD_WIDTH'(1);
            end
         end
         ST_WAIT: begin
            timer_en = 1'b1;
            // A done arriving on the expiry cycle still counts.
            if (done_hit) begin
               state_d = ST_WRITE;
            end else if (timer_expire) begin
               err_to_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_WRITE: begin
            out_cnt_d = out_cnt_q - CNT_WIDTH'(1);
            if (out_cnt_q == CNT_WIDTH'(1)) begin
               state_d = ST_DONE;
            end else begin
               word_cnt_d = '0;
               state_d    = ST_LOAD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_NOP;
         out_cnt_q    <= '0;
         word_cnt_q   <= '0;
         word_total_q <= '0;
         layer_q      <= 1'b0;
         err_ill_q    <= 1'b0;
         err_to_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         out_cnt_q    <= out_cnt_d;
         word_cnt_q   <= word_cnt_d;
         word_total_q <= word_total_d;
         layer_q      <= layer_d;
         err_ill_q    <= err_ill_d;
         err_to_q     <= err_to_d;
      end
   end

   assign instr_ready         = (state_q == ST_IDLE);
   assign busy                = (state_q != ST_IDLE);
   assign data_req            = (state_q == ST_LOAD);
   assign fully_convol_signal = (state_q == ST_LOAD) && (mode_q != MODE_POOL);
   assign pooling_signal      = (state_q == ST_LOAD) && (mode_q == MODE_POOL);
   assign write_signal        = (state_q == ST_WRITE);
   assign layer_done          = (state_q == ST_DONE);
   assign layer_signal        = layer_q;
   assign err_illegal         = err_ill_q;
   assign err_timeout         = err_to_q;

endmodule

// File: tb/tb_mito_layer_sequencer.sv
module tb_mito_layer_sequencer;

   localparam int TO = 1024;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic        act_done;
   logic        pool_done;
   logic        layer_signal;
   logic        fully_convol_signal;
   logic        pooling_signal;
   logic        data_req;
   logic        write_signal;
   logic        busy;
   logic        layer_done;
   logic        err_illegal;
   logic        err_timeout;

   mito_layer_sequencer #(
      .INSTR_WIDTH(32), .CNT_WIDTH(16), .LOAD_WIDTH(8), .POOL_SIZE(4), .TIMEOUT(TO)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .instr_valid         (instr_valid),
      .instr_ready         (instr_ready),
      .instruction         (instruction),
      .act_done            (act_done),
      .pool_done           (pool_done),
      .layer_signal        (layer_signal),
      .fully_convol_signal (fully_convol_signal),
      .pooling_signal      (pooling_signal),
      .data_req            (data_req),
      .write_signal        (write_signal),
      .busy                (busy),
      .layer_done          (layer_done),
      .err_illegal         (err_illegal),
      .err_timeout         (err_timeout)
   );

   // ---------------- clock / cycle counter ----------------
   int cyc = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor (negedge sampling) ----------------
   int n_dreq = 0, n_fc = 0, n_pool = 0, n_write = 0, n_done = 0;
   int n_ill = 0, n_to = 0, n_runs = 0;
   int run_len = 0, wait_entry = -100000, to_lat = 0;
   int last_write_cyc = 0, done_cyc = 0;
   int lat_log [64];
   int run_log [64];
   logic dreq_prev = 1'b0;

   always @(negedge clk) begin
      dreq_prev <= data_req;
      if (data_req) begin
         n_dreq  <= n_dreq + 1;
         run_len <= dreq_prev ? run_len + 1 : 1;
      end else if (dreq_prev) begin
         run_log[n_runs % 64] <= run_len;
         n_runs     <= n_runs + 1;
         wait_entry <= cyc;
      end
      if (fully_convol_signal) n_fc <= n_fc + 1;
      if (pooling_signal)      n_pool <= n_pool + 1;
      if (write_signal) begin
         lat_log[n_write % 64] <= cyc - wait_entry;
         last_write_cyc <= cyc;
         n_write <= n_write + 1;
      end
      if (layer_done) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (err_illegal) n_ill <= n_ill + 1;
      if (err_timeout) begin
         n_to   <= n_to + 1;
         to_lat <= cyc - wait_entry;
      end
   end

   // ---------------- completion-pulse responder ----------------
   logic resp_on = 1'b0, resp_pool = 1'b0, stray_on = 1'b0;
   int   resp_delay = 0, stray_delay = 0, load_act_cyc = -1;

   initial begin : responder
      act_done  = 1'b0;
      pool_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         act_done  = 1'b0;
         pool_done = 1'b0;
         if (resp_on && cyc == wait_entry + resp_delay) begin
            if (resp_pool) pool_done = 1'b1;
            else           act_done  = 1'b1;
         end
         if (stray_on && cyc == wait_entry + stray_delay) act_done = 1'b1;
         if (cyc == load_act_cyc) act_done = 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0, n_fail = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Write latencies (cycles from WAIT entry to write strobe) against exp_q.
   task automatic check_lats(input string tag, input int first);
      int idx;
      idx = first;
      while (exp_q.size() > 0) begin
         check(tag, lat_log[idx % 64], exp_q.pop_front());
         idx++;
      end
   endtask

   function automatic logic [9:0] outs_vec();
      return {instr_ready, layer_signal, fully_convol_signal, pooling_signal, data_req,
              write_signal, busy, layer_done, err_illegal, err_timeout};
   endfunction
   localparam logic [9:0] RESET_VEC = 10'b10_0000_0000;

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1: offers the instruction for exactly one cycle.
   task automatic send_instr(input logic [1:0] mode, input int nout, input int lw);
      logic [15:0] n16;
      logic [7:0]  l8;
      n16 = 16'(nout);
      l8  = 8'(lw);
      instruction = {6'b0, l8, n16, mode};
      instr_valid = 1'b1;
      idle(1);
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < max);
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   int s_dreq, s_fc, s_pool, s_write, s_done, s_ill, s_to, s_runs;
   task automatic snap();
      s_dreq = n_dreq; s_fc = n_fc; s_pool = n_pool; s_write = n_write;
      s_done = n_done; s_ill = n_ill; s_to = n_to; s_runs = n_runs;
   endtask

   initial begin : main
      int k;
      rst = 1'b1;
      instr_valid = 1'b0;
      instruction = '0;
      repeat (3) @(negedge clk);
      check("reset_outs_in_reset", 32'(outs_vec()), 32'(RESET_VEC));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outs_after", 32'(outs_vec()), 32'(RESET_VEC));
      idle(2);

      // CONVOL: 2 outputs x 9 words, act_done 3 cycles into WAIT
      snap();
      resp_on = 1'b1; resp_pool = 1'b0; resp_delay = 3;
      exp_q.push_back(4); exp_q.push_back(4);
      send_instr(2'b01, 2, 9);
      wait_idle("conv_finish", 200);
      idle(2);
      check("conv_dreq", n_dreq - s_dreq, 18);
      check("conv_fc", n_fc - s_fc, 18);
      check("conv_pool", n_pool - s_pool, 0);
      check("conv_runs", n_runs - s_runs, 2);
      check("conv_run0", run_log[s_runs % 64], 9);
      check("conv_run1", run_log[(s_runs + 1) % 64], 9);
      check("conv_writes", n_write - s_write, 2);
      check_lats("conv_lat", s_write);
      check("conv_done", n_done - s_done, 1);
      check("conv_done_after_write", done_cyc - last_write_cyc, 1);
      check("conv_layer_sig", {31'd0, layer_signal}, 0);

      // POOL: 3 outputs, pool_done 1 cycle into WAIT; load_words=0 is legal here
      snap();
      resp_pool = 1'b1; resp_delay = 1;
      for (int i = 0; i < 3; i++) exp_q.push_back(2);
      send_instr(2'b11, 3, 0);
      wait_idle("pool_finish", 200);
      idle(2);
      check("pool_pool", n_pool - s_pool, 12);
      check("pool_fc", n_fc - s_fc, 0);
      for (int i = 0; i < 3; i++) check("pool_run", run_log[(s_runs + i) % 64], 4);
      check("pool_writes", n_write - s_write, 3);
      check_lats("pool_lat", s_write);
      check("pool_done", n_done - s_done, 1);
      check("pool_ill", n_ill - s_ill, 0);
      check("pool_layer_hold", {31'd0, layer_signal}, 1);

      // Illegal instructions: NOP mode, zero outputs, CONVOL with zero words
      resp_on = 1'b0;
      for (int t = 0; t < 3; t++) begin
         snap();
         case (t)
            0:       send_instr(2'b00, 1, 1);
            1:       send_instr(2'b01, 0, 3);
            default: send_instr(2'b01, 2, 0);
         endcase
         @(negedge clk);
         check("ill_pulse", {31'd0, err_illegal}, 1);
         check("ill_outs", 32'(outs_vec()), 32'(10'b11_0000_0010));
         idle(2);
         check("ill_count", n_ill - s_ill, 1);
         check("ill_dreq", n_dreq - s_dreq, 0);
      end

      // FULLY with no act_done: abort on timeout
      snap();
      send_instr(2'b10, 1, 4);
      wait_idle("to_finish", TO + 50);
      idle(2);
      check("to_count", n_to - s_to, 1);
      check("to_latency", to_lat, TO);
      check("to_writes", n_write - s_write, 0);
      check("to_done", n_done - s_done, 0);
      check("to_fc", n_fc - s_fc, 4);
      check("to_layer_sig", {31'd0, layer_signal}, 0);

      // act_done on the expiry cycle wins
      snap();
      resp_on = 1'b1; resp_pool = 1'b0; resp_delay = TO - 1;
      exp_q.push_back(TO);
      send_instr(2'b01, 1, 2);
      wait_idle("exp_finish", TO + 50);
      idle(2);
      check("exp_writes", n_write - s_write, 1);
      check_lats("exp_lat", s_write);
      check("exp_to", n_to - s_to, 0);
      check("exp_done", n_done - s_done, 1);

      // act_done during LOAD is not remembered
      snap();
      resp_delay = 6;
      load_act_cyc = cyc + 2;
      exp_q.push_back(7);
      send_instr(2'b01, 1, 5);
      wait_idle("ld_finish", 200);
      idle(2);
      check("ld_writes", n_write - s_write, 1);
      check_lats("ld_lat", s_write);

      // stray act_done while a POOL layer waits
      snap();
      resp_pool = 1'b1; resp_delay = 3;
      stray_on = 1'b1; stray_delay = 1;
      exp_q.push_back(4);
      send_instr(2'b11, 1, 0);
      wait_idle("stray_finish", 200);
      idle(2);
      stray_on = 1'b0;
      check("stray_writes", n_write - s_write, 1);
      check_lats("stray_lat", s_write);

      // instr_valid while busy is refused
      snap();
      resp_pool = 1'b0; resp_delay = 2;
      send_instr(2'b01, 1, 3);
      instruction = {6'b0, 8'd1, 16'd1, 2'b11};
      instr_valid = 1'b1;
      @(negedge clk);
      check("busy_ready", {31'd0, instr_ready}, 0);
      idle(1);
      instr_valid = 1'b0;
      wait_idle("busy_finish", 200);
      idle(3);
      check("busy_pool", n_pool - s_pool, 0);
      check("busy_done", n_done - s_done, 1);
      check("busy_layer_sig", {31'd0, layer_signal}, 0);
      check("busy_idle_after", {31'd0, busy}, 0);

      // Reset while waiting with 5 outputs pending
      resp_on = 1'b0;
      send_instr(2'b01, 5, 2);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (data_req && k < 20);
      check("rst_reached_wait", {31'd0, busy & ~data_req}, 1);
      snap();
      #2 rst = 1'b1;
      #1 check("rst_async_outs", 32'(outs_vec()), 32'(RESET_VEC));
      idle(2);
      rst = 1'b0;
      idle(2);
      check("rst_no_done", n_done - s_done, 0);
      check("rst_no_err", (n_to - s_to) + (n_ill - s_ill), 0);
      snap();
      resp_on = 1'b1; resp_pool = 1'b1; resp_delay = 1;
      exp_q.push_back(2); exp_q.push_back(2);
      send_instr(2'b11, 2, 0);
      wait_idle("rst_pool_finish", 200);
      idle(2);
      check("rst_pool_pool", n_pool - s_pool, 8);
      check("rst_pool_writes", n_write - s_write, 2);
      check_lats("rst_pool_lat", s_write);
      check("rst_pool_done", n_done - s_done, 1);
      check("rst_pool_layer_sig", {31'd0, layer_signal}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mito_layer_sequencer.md
Name: mito_layer_sequencer

Overview:
- Instruction-driven sequencer for one MITO layer: accepts a decoded layer instruction, then steps the datapath through load, compute and write phases once per output element.
- Drives the layer-select, main-buffer load enable, pooling enable and OFM write strobe.
- Consumes completion pulses from the activation and max-pooling stages.
- Sits between the host instruction port and the buffer/PE/pooling datapath, replacing the free-running controller with a counted, handshaked one.

Parameters:
- INSTR_WIDTH, 32, instruction word width
- CNT_WIDTH, 16, width of output-count field/counter
- LOAD_WIDTH, 8, width of words-per-output field/counter
- POOL_SIZE, 4, input words per pooling window
- TIMEOUT, 1024, max cycles in WAIT before abort

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept instruction
- instruction  in  INSTR_WIDTH  [1:0] mode, [17:2] num_outputs, [25:18] load_words, [31:26] reserved (ignored)
- act_done  in  1  activation result ready (1-cycle pulse)
- pool_done  in  1  pooling result ready (1-cycle pulse)
- layer_signal  out  1  0 = main buffer/activation path, 1 = pooling path
- fully_convol_signal  out  1  main buffer load enable
- pooling_signal  out  1  pooling input enable
- data_req  out  1  host must present one input word this cycle
- write_signal  out  1  OFM buffer write strobe
- busy  out  1  not in IDLE
- layer_done  out  1  1-cycle pulse, layer complete
- err_illegal  out  1  1-cycle pulse, bad instruction rejected
- err_timeout  out  1  1-cycle pulse, WAIT timed out, layer aborted

Behaviour:
- Reset and clocking:
  - Single clock domain; rst asynchronous, active-high.
  - Reset state: IDLE, all counters 0, layer_signal 0, every other output 0 except instr_ready = 1.
  - Reset mid-layer aborts immediately; no layer_done, no error pulse.
- Modes: 00 NOP, 01 CONVOL, 10 FULLY, 11 POOL.
- All outputs decoded from registered state/mode/counters; no combinational path from input to output except none required.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, check for illegal instruction: mode 00, num_outputs 0, or load_words 0 with mode != 11.
  - Illegal: err_illegal pulses next cycle, stay IDLE.
  - Legal: latch mode; out_cnt = num_outputs; word_total = load_words (CONVOL/FULLY) or POOL_SIZE (POOL); layer_signal = (mode == 11); go to LOAD.
- LOAD:
  - data_req = 1.
  - fully_convol_signal = 1 if mode is CONVOL/FULLY; pooling_signal = 1 if POOL.
  - Exactly word_total cycles, counted by word_cnt, then go to WAIT with timer cleared.
- WAIT:
  - Awaits act_done (CONVOL/FULLY) or pool_done (POOL); the other pulse is ignored.
  - Timer increments each cycle.
  - Expected done seen: go to WRITE.
  - Timer reaches TIMEOUT-1 without done: err_timeout pulse, go to IDLE.
  - Done in the same cycle as expiry: done wins.
- WRITE:
  - write_signal = 1 for exactly one cycle; out_cnt decrements.
  - If out_cnt was 1, go to DONE; else go to LOAD, which reloads word_cnt.
- DONE: layer_done = 1 for one cycle, then IDLE.
- Done pulses outside WAIT are ignored and not remembered.
- instr_valid outside IDLE is ignored (instr_ready = 0).
- layer_signal holds its value through DONE and IDLE until the next accepted instruction.
- busy = 1 in LOAD, WAIT, WRITE, DONE.
- Latency:
  - Accept at cycle T gives LOAD cycles T+1..T+L.
  - WAIT begins at T+L+1.
  - Done at cycle D gives write_signal at D+1.
  - Next LOAD begins at D+2.
  - layer_done at D+2 after the last write.
- Counter widths: out_cnt CNT_WIDTH, word_cnt LOAD_WIDTH (POOL_SIZE must fit), timer clog2(TIMEOUT).
  - Counters never wrap: maximum num_outputs is 65535 and is legal.

Decomposition:
- Shared package mito_pkg:
  - mode enum (NOP/CONVOL/FULLY/POOL) replacing the per-module 2-bit parameters.
  - Sequencer state enum.
  - Instruction field offset/width constants.
  - Packed instruction struct.
- One sub-module: mito_wait_timer (clear/enable/expire, parameter TIMEOUT). Everything else stays in one FSM.

Test Plan:
- CONVOL, num_outputs=2, load_words=9, act_done 3 cycles after WAIT entry:
  - data_req and fully_convol_signal high exactly 9 cycles twice.
  - write_signal pulses twice, 4 cycles after each WAIT entry.
  - layer_done once; layer_signal=0 throughout.
- POOL, num_outputs=3, pool_done 1 cycle after WAIT:
  - pooling_signal exactly 4 cycles per output; layer_signal=1.
  - 3 writes, then layer_done.
  - A stray act_done during WAIT is ignored.
- Illegal instructions: mode=00, num_outputs=0, and CONVOL with load_words=0:
  - err_illegal pulse each time; busy stays 0; no other output toggles.
- FULLY, num_outputs=1, load_words=4, no act_done:
  - err_timeout exactly TIMEOUT cycles after WAIT entry; returns to IDLE; no write_signal, no layer_done.
- Timing corners:
  - act_done on the expiry cycle yields a write, not a timeout.
  - act_done during LOAD is ignored and the FSM still waits in WAIT.
  - instr_valid while busy is not accepted.
- Reset in WAIT with out_cnt=5:
  - All outputs return to reset values asynchronously.
  - A fresh POOL instruction then runs normally.
